// File: rtl/id_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among NUM_REQ requesters.
// Serialises single-word reads/writes, honours waitrequest, aborts stalled commands.
module id_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [16*NUM_REQ-1:0]   req_address,
  input  logic [32*NUM_REQ-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]      rsp_done,
  output logic [31:0]             rsp_readdata,
  output logic                    rsp_error,
  output logic [15:0]             avalon_master_address,
  output logic                    avalon_master_read,
  output logic                    avalon_master_write,
  output logic [31:0]             avalon_master_writedata,
  input  logic [31:0]             avalon_master_readdata,
  input  logic                    avalon_master_waitrequest
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     grant_reg, grant_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 read_reg, read_next;
  logic                 write_reg, write_next;
  logic [15:0]          addr_reg, addr_next;
  logic [31:0]          wdata_reg, wdata_next;
  logic [NUM_REQ-1:0]   done_reg, done_next;
  logic [31:0]          rdata_reg, rdata_next;
  logic                 error_reg, error_next;

  logic [15:0]          req_addr_arr  [NUM_REQ];
  logic [31:0]          req_wdata_arr [NUM_REQ];
  logic [IDX_W:0]       rot_sum [NUM_REQ];
  logic [IDX_W-1:0]     rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   rot_valid;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  // rot_idx[k] is the requester k positions after rr_ptr, wrapping at NUM_REQ
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_addr_arr[gi]  = req_address[16*gi +: 16];
      assign req_wdata_arr[gi] = req_writedata[32*gi +: 32];
      assign rot_sum[gi]       = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign rot_idx[gi]       = (rot_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                                 ? IDX_W'(rot_sum[gi] - (IDX_W+1)'(NUM_REQ))
                                 : IDX_W'(rot_sum[gi]);
      assign rot_valid[gi]     = req_valid[rot_idx[gi]];
    end
  endgenerate

  // Scan downward so the smallest offset from rr_ptr ends up winning
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      cnt_reg    <= '0;
      read_reg   <= 1'b0;
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      done_reg   <= '0;
      rdata_reg  <= '0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      cnt_reg    <= cnt_next;
      read_reg   <= read_next;
      write_reg  <= write_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      done_reg   <= done_next;
      rdata_reg  <= rdata_next;
      error_reg  <= error_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    cnt_next    = cnt_reg;
    read_next   = read_reg;
    write_next  = write_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    done_next   = '0;
    rdata_next  = rdata_reg;
    error_next  = error_reg;

    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_idx;
          read_next  = ~req_write[pick_idx];
          write_next = req_write[pick_idx];
          addr_next  = req_addr_arr[pick_idx];
          wdata_next = req_wdata_arr[pick_idx];
          cnt_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Acceptance is checked first so it wins over a same-cycle timeout
        if (!avalon_master_waitrequest) begin
          read_next             = 1'b0;
          write_next            = 1'b0;
          rdata_next            = write_reg ? 32'h0 : avalon_master_readdata;
          error_next            = 1'b0;
          done_next[grant_reg]  = 1'b1;
          state_next            = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          read_next             = 1'b0;
          write_next            = 1'b0;
          rdata_next            = TIMEOUT_DATA;
          error_next            = 1'b1;
          done_next[grant_reg]  = 1'b1;
          state_next            = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        rr_ptr_next = (grant_reg == IDX_LAST) ? '0 : grant_reg + 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rsp_done                = done_reg;
  assign rsp_readdata            = rdata_reg;
  assign rsp_error               = error_reg;
  assign avalon_master_address   = addr_reg;
  assign avalon_master_read      = read_reg;
  assign avalon_master_write     = write_reg;
  assign avalon_master_writedata = wdata_reg;

endmodule

// File: tb/tb_id_bus_arbiter.sv
// Directed bench for id_bus_arbiter: reset, latency, round-robin order,
// waitrequest handling, timeout abort and reset during a stalled command.
module tb_id_bus_arbiter;

  localparam int NR = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_write = '0;
  logic [16*NR-1:0]  req_address = '0;
  logic [32*NR-1:0]  req_writedata = '0;
  logic [NR-1:0]     rsp_done;
  logic [31:0]       rsp_readdata;
  logic              rsp_error;
  logic [15:0]       avalon_master_address;
  logic              avalon_master_read;
  logic              avalon_master_write;
  logic [31:0]       avalon_master_writedata;
  logic [31:0]       avalon_master_readdata;
  logic              avalon_master_waitrequest;

  int errors = 0;
  int checks = 0;

  // Slave model: stalls each command for slave_waits cycles, then accepts
  int          slave_waits = 0;
  int          wait_cnt = 0;
  logic        use_addr = 1'b0;
  logic [31:0] slave_data = '0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if ((avalon_master_read || avalon_master_write) && avalon_master_waitrequest)
      wait_cnt <= wait_cnt + 1;
    else
      wait_cnt <= 0;
  end

  assign avalon_master_waitrequest = (avalon_master_read || avalon_master_write) &&
                                     (wait_cnt < slave_waits);
  assign avalon_master_readdata    = use_addr ? {16'hCAFE, avalon_master_address} : slave_data;

  id_bus_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .req_valid                 (req_valid),
    .req_write                 (req_write),
    .req_address               (req_address),
    .req_writedata             (req_writedata),
    .rsp_done                  (rsp_done),
    .rsp_readdata              (rsp_readdata),
    .rsp_error                 (rsp_error),
    .avalon_master_address     (avalon_master_address),
    .avalon_master_read        (avalon_master_read),
    .avalon_master_write       (avalon_master_write),
    .avalon_master_writedata   (avalon_master_writedata),
    .avalon_master_readdata    (avalon_master_readdata),
    .avalon_master_waitrequest (avalon_master_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and check the always-true bus invariants
  task automatic step();
    @(negedge clock);
    chk("rd_wr_exclusive", 32'(avalon_master_read && avalon_master_write), 32'h0);
    chk("done_onehot0", 32'($onehot0(rsp_done)), 32'h1);
  endtask

  // Called at the falling edge of an IDLE cycle; the grant happens on the next rising edge
  task automatic txn(input int idx, input logic [15:0] addr, input logic wr,
                     input logic [31:0] wd, input int held,
                     input logic [31:0] rd, input logic err);
    for (int c = 0; c < held; c++) begin
      step();
      chk("cmd_read", 32'(avalon_master_read), 32'(!wr));
      chk("cmd_write", 32'(avalon_master_write), 32'(wr));
      chk("cmd_addr", 32'(avalon_master_address), 32'(addr));
      if (wr) chk("cmd_wdata", avalon_master_writedata, wd);
      chk("done_during_issue", 32'(rsp_done), 32'h0);
    end
    step();
    chk("done_onehot", 32'(rsp_done), 32'(1 << idx));
    chk("rsp_readdata", rsp_readdata, rd);
    chk("rsp_error", 32'(rsp_error), 32'(err));
    chk("cmd_dropped", 32'({avalon_master_read, avalon_master_write}), 32'h0);
    $display("txn req=%0d addr=%h %s held=%0d rdata=%h err=%b",
             idx, addr, wr ? "WR" : "RD", held, rsp_readdata, rsp_error);
    step();
    chk("done_cleared", 32'(rsp_done), 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, 32'(avalon_master_read), 32'h0);
    chk({tag, "_write"}, 32'(avalon_master_write), 32'h0);
    chk({tag, "_addr"}, 32'(avalon_master_address), 32'h0);
    chk({tag, "_wdata"}, avalon_master_writedata, 32'h0);
    chk({tag, "_done"}, 32'(rsp_done), 32'h0);
    chk({tag, "_rdata"}, rsp_readdata, 32'h0);
    chk({tag, "_error"}, 32'(rsp_error), 32'h0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;

    // Single read, one-wait slave: read in cycles 1-2, done in cycle 3
    req_address = {16'h0340, 16'h0230, 16'h0120, 16'h0100};
    slave_waits = 1;
    slave_data  = 32'h0000000A;
    req_valid   = 4'b0001;
    txn(0, 16'h0100, 1'b0, 32'h0, 2, 32'h0000000A, 1'b0);
    req_valid   = 4'b0000;

    // Write from requester 2 against a 5-wait slave
    req_write     = 4'b0100;
    req_address   = {16'h0340, 16'h0200, 16'h0120, 16'h0010};
    req_writedata = {32'h0, 32'h12345678, 32'h0, 32'h0};
    slave_waits   = 5;
    req_valid     = 4'b0100;
    txn(2, 16'h0200, 1'b1, 32'h12345678, 6, 32'h0, 1'b0);
    req_valid     = 4'b0000;
    req_write     = 4'b0000;

    // Fresh reset so contention starts from rr_ptr 0
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Contention: all requesters, zero-wait slave, order 0,1,2,3,0
    req_address = {16'h0340, 16'h0230, 16'h0120, 16'h0010};
    use_addr    = 1'b1;
    slave_waits = 0;
    req_valid   = 4'b1111;
    txn(0, 16'h0010, 1'b0, 32'h0, 1, 32'hCAFE0010, 1'b0);
    txn(1, 16'h0120, 1'b0, 32'h0, 1, 32'hCAFE0120, 1'b0);
    txn(2, 16'h0230, 1'b0, 32'h0, 1, 32'hCAFE0230, 1'b0);
    txn(3, 16'h0340, 1'b0, 32'h0, 1, 32'hCAFE0340, 1'b0);
    txn(0, 16'h0010, 1'b0, 32'h0, 1, 32'hCAFE0010, 1'b0);

    // Fairness: 1 and 3 held, 0 raised once; expect 1,3,0,1,3
    req_valid = 4'b1010;
    txn(1, 16'h0120, 1'b0, 32'h0, 1, 32'hCAFE0120, 1'b0);
    req_valid = 4'b1011;
    txn(3, 16'h0340, 1'b0, 32'h0, 1, 32'hCAFE0340, 1'b0);
    txn(0, 16'h0010, 1'b0, 32'h0, 1, 32'hCAFE0010, 1'b0);
    req_valid = 4'b1010;
    txn(1, 16'h0120, 1'b0, 32'h0, 1, 32'hCAFE0120, 1'b0);
    txn(3, 16'h0340, 1'b0, 32'h0, 1, 32'hCAFE0340, 1'b0);
    req_valid = 4'b0000;

    // Timeout: slave never releases, read held exactly 8 cycles
    slave_waits = 1000;
    req_valid   = 4'b0010;
    txn(1, 16'h0120, 1'b0, 32'h0, 8, 32'hDEADBEEF, 1'b1);
    slave_waits = 0;
    req_valid   = 4'b0100;
    txn(2, 16'h0230, 1'b0, 32'h0, 1, 32'hCAFE0230, 1'b0);
    req_valid   = 4'b0000;

    // Reset during the 2nd wait cycle of a stalled read from requester 3
    slave_waits = 5;
    req_valid   = 4'b1000;
    step();
    chk("pre_reset_read_c1", 32'(avalon_master_read), 32'h1);
    step();
    chk("pre_reset_read_c2", 32'(avalon_master_read), 32'h1);
    reset = 1'b1;
    step();
    chk_all_zero("mid_reset");
    reset       = 1'b0;
    slave_waits = 0;
    req_valid   = 4'b1001;
    txn(0, 16'h0010, 1'b0, 32'h0, 1, 32'hCAFE0010, 1'b0);
    txn(3, 16'h0340, 1'b0, 32'h0, 1, 32'hCAFE0340, 1'b0);
    req_valid   = 4'b0000;
    step();
    chk("idle_no_cmd", 32'({avalon_master_read, avalon_master_write}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_bus_arbiter.md
# id_bus_arbiter

Round-robin arbiter that shares one Avalon-MM master port between NUM_REQ local requesters, e.g. triangulation channel logic polling the ID-switch slave and other register slaves. It serialises single-word read/write transactions, honours slave waitrequest, and aborts transactions that stall beyond a timeout with an error response. It sits between the fabric-side requesters and the Avalon interconnect in front of the peripheral slaves.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 256, max cycles a command may be held in waitrequest before abort (≥2)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; no other clock domains
- req_valid  in  NUM_REQ  per-requester transaction request, held until its done pulse
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_address  in  16*NUM_REQ  packed per-requester word address (requester i at [16i+15:16i])
- req_writedata  in  32*NUM_REQ  packed per-requester write data
- rsp_done  out  NUM_REQ  one-cycle completion pulse to the owning requester
- rsp_readdata  out  32  read result, valid while rsp_done is nonzero
- rsp_error  out  1  timeout flag, valid while rsp_done is nonzero
- avalon_master_address  out  16  bus address
- avalon_master_read  out  1  read command
- avalon_master_write  out  1  write command
- avalon_master_writedata  out  32  bus write data
- avalon_master_readdata  in  32  slave read data
- avalon_master_waitrequest  in  1  slave stall

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: if any req_valid set, pick the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …). Register grant index, latch that requester's write, address, writedata into bus output registers, clear timeout counter, go to ISSUE. No request: stay.
- ISSUE: avalon_master_read = ~latched write, avalon_master_write = latched write; address and writedata stable throughout.
  - Accept: on a cycle with command asserted and waitrequest = 0, capture readdata (reads only; writes capture 0), error = 0, deassert command, go to DONE.
  - Timeout: counter increments each ISSUE cycle with waitrequest = 1; when it reaches TIMEOUT_CYCLES-1 while waitrequest is still 1, deassert command, readdata = 32'hDEADBEEF, error = 1, go to DONE. Accept on that same cycle wins over timeout.
- DONE: rsp_done[grant] = 1 for exactly this cycle; rsp_readdata and rsp_error driven; rr_ptr = (grant+1) mod NUM_REQ; go to IDLE.
- Latched command is fixed for the whole transaction; req_valid dropping during ISSUE does not abort it. The requester still receives rsp_done.
- A requester that keeps req_valid high after done is re-eligible immediately but ranks behind the others.
- Address is passed through unmodified; the slave decodes address>>8.

## Timing
- Reset: state IDLE, rr_ptr 0, rsp_done 0, rsp_error 0, rsp_readdata 0, avalon_master_read/write 0, address 0, writedata 0, timeout counter 0.
- Reset asserted mid-transaction: bus command drops on the next edge; no rsp_done is issued for the aborted transaction.
- Latency, with req_valid first high in cycle 0 and IDLE:
  - Command appears on the bus in cycle 1.
  - A zero-wait slave accepts in cycle 1; rsp_done is in cycle 2.
  - A one-wait slave, such as the ID switch, accepts in cycle 2; rsp_done is in cycle 3.
- Minimum spacing between back-to-back transactions is 3 cycles: IDLE, ISSUE, DONE.
- Timeout: the command stays asserted for exactly TIMEOUT_CYCLES cycles, then DONE follows.
- At most one bit of rsp_done is set in any cycle. Read and write are never both asserted.

## Test plan
- Single read: requester 0 reads address 16'h0100 from a one-wait slave returning 32'h0000000A. Required: read high in cycles 1–2, rsp_done = 4'b0001 in cycle 3, rsp_readdata = 32'h0000000A, rsp_error = 0.
- Contention: all four req_valid high and held after reset, zero-wait slave. Required: grants in order 0,1,2,3,0…, one rsp_done every 3 cycles.
- Round-robin fairness: req1 and req3 held continuously, with req0 raised once mid-stream. Required: req0 is served no later than 2 transactions after rising, and 1 and 3 alternate.
- Write: requester 2 writes 32'h12345678 to 16'h0200 against a 5-wait slave. Required: write held 6 cycles with stable address and data, then rsp_done = 4'b0100 and rsp_error = 0.
- Timeout: TIMEOUT_CYCLES = 8, waitrequest tied high. Required: read held exactly 8 cycles, then rsp_readdata = 32'hDEADBEEF and rsp_error = 1. Next requester is then serviced normally.
- Reset mid-ISSUE: reset asserted during the 2nd wait cycle. Required: all outputs 0 next cycle, no rsp_done, and the first grant after reset goes to requester 0.
